clockport_master: RTL and testbench
===================================

# clockport_master

Synthesisable, parametrised Amiga clockport bus master. It accepts read and write commands from the host-side logic through a valid/ready queue and executes them one at a time on the clockport (CS_n, IORD_n, IOWR_n, A, D). Strobe setup, width, hold and recovery are programmable, with per-command extra wait states. Completions are returned on a response port, and INT6_n is synchronised into an interrupt pulse. It sits between the Pi-side register/bridge logic and the clockport pins.

## Interface
- ADDR_W, 2: clockport address width, 2..8.
- DATA_W, 8: data bus width.
- FIFO_DEPTH, 4: command queue depth; power of two, at least 2.
- WAIT_W, 3: width of the per-command wait-state field.
- T_SETUP, 2: cycles from CS_n low to strobe low; at least 1.
- T_STROBE, 3: base strobe-low cycles; at least 1.
- T_HOLD, 1: cycles from strobe high to CS_n high; at least 1.
- T_RECOVER, 1: extra idle cycles after CS_n high; at least 0.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  queue not full.
- cmd_rnw  in  1  1 = read, 0 = write.
- cmd_addr  in  ADDR_W  address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wait  in  WAIT_W  extra strobe cycles for this access.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rnw  out  1  type of the completed access.
- rsp_rdata  out  DATA_W  read data; held until the next read completes.
- A  out  ADDR_W  clockport address.
- D_out  out  DATA_W  write data to the pad.
- D_oe  out  1  pad output enable.
- D_in  in  DATA_W  data from the pad.
- CS_n, IORD_n, IOWR_n  out  1 each  bus strobes, active-low.
- INT6_n  in  1  asynchronous interrupt input, active-low.
- irq_pulse  out  1  one cycle per synchronised falling edge of INT6_n.
- irq_level  out  1  synchronised, inverted INT6_n.

## Operation
- **Queue.** A command is pushed when cmd_valid && cmd_ready.
  - cmd_ready = !full, registered-only decision: a full queue refuses a push even in a cycle where it pops.
  - Order is FIFO.
  - Empty: the controller stays in IDLE.
- **State machine:** IDLE, SETUP, STROBE, HOLD, RECOVER. One down-counter is loaded on each transition.
  - IDLE: if the queue is not empty, pop. Latch rnw/addr/wdata/wait. CS_n<=0, A<=addr, D_oe<=!rnw, D_out<=wdata. Go to SETUP (T_SETUP cycles).
  - SETUP end: IORD_n<=0 (read) or IOWR_n<=0 (write). Go to STROBE (T_STROBE+wait cycles; width T_STROBE+WAIT_W+1 bits, no overflow).
  - STROBE end: strobe<=1. For a read, rsp_rdata<=D_in is sampled on this same edge. Go to HOLD (T_HOLD cycles). D_oe and A are held.
  - HOLD end: CS_n<=1, D_oe<=0, A<=0, rsp_valid<=1 for 1 cycle with rsp_rnw. Go to RECOVER, or straight to IDLE if T_RECOVER=0.
  - RECOVER end: go to IDLE.
- **Interrupt.** INT6_n passes through a two-flop synchroniser; both flops reset to 1.
  - irq_level = !sync.
  - irq_pulse = prev_sync && !sync.
  - Independent of bus activity.
- **Reset** (async, any time, including mid-strobe):
  - CS_n, IORD_n, IOWR_n = 1; D_oe = 0; A, D_out, rsp_rdata = 0.
  - rsp_valid, irq_pulse, irq_level = 0; cmd_ready = 1.
  - Queue flushed; state = IDLE.
  - An in-flight access produces no response.

## Timing
- All outputs are registered; no combinational path from inputs to bus pins.
- Command accepted at edge k is popped at edge k+1 (when the queue was empty and IDLE).
- With CS_n falling at edge E:
  - strobe falls at E+T_SETUP;
  - strobe rises at E+T_SETUP+T_STROBE+W;
  - CS_n rises and rsp_valid asserts at E+T_SETUP+T_STROBE+W+T_HOLD.
- Strobe low width = T_STROBE+W cycles.
- CS_n high between back-to-back accesses = T_RECOVER+1 cycles minimum.
- Write data is valid on D from the CS_n fall until the CS_n rise, covering the strobe on both sides.
- IORD_n and IOWR_n are never low simultaneously.
- irq_pulse latency: 2–3 cycles after the INT6_n fall.

## Test plan
- **Single write** (defaults): write A=2, D=0xA5, wait=0, accepted edge 0.
  - CS_n low after edge 1; IOWR_n low after edges 3..6; CS_n high after edge 7.
  - D_oe=1 over edges 1..7; rsp_valid=1, rsp_rnw=0 in the cycle after edge 7.
- **Read with waits:** read A=1, wait=2, D_in=0x3C.
  - IORD_n low for 5 cycles; rsp_rdata=0x3C; D_oe stays 0; rsp_valid one cycle.
- **Queue full / back-to-back:** push 6 commands continuously.
  - cmd_ready drops after 4 queued entries.
  - All 6 execute in order, with CS_n high exactly 2 cycles between accesses.
- **Reset mid-strobe:** assert reset while IOWR_n=0.
  - Same cycle: IOWR_n=1, CS_n=1, D_oe=0.
  - Queued commands are lost, no rsp_valid, cmd_ready=1.
- **Interrupt:** drive INT6_n 1→0 asynchronously during a read.
  - One irq_pulse within 3 cycles; irq_level=1 until INT6_n returns to 1.
  - Bus timing unaffected.
- **Max wait:** wait=7 (WAIT_W=3), T_STROBE=3.
  - Strobe low for exactly 10 cycles; counter does not wrap.

Source files
------------

// File: rtl/clockport_master.sv
// clockport_master: Amiga clockport bus master.
// Host commands are queued in a small FIFO and executed one at a time as
// CS_n / IORD_n / IOWR_n cycles with programmable setup, strobe, hold and
// recovery times. Completions come back as a one-cycle response pulse, and
// INT6_n is synchronised into a level and a falling-edge pulse.
module clockport_master #(
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int WAIT_W     = 3,
  parameter int T_SETUP    = 2,
  parameter int T_STROBE   = 3,
  parameter int T_HOLD     = 1,
  parameter int T_RECOVER  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rnw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [WAIT_W-1:0] cmd_wait,
  output logic              rsp_valid,
  output logic              rsp_rnw,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D_out,
  output logic              D_oe,
  input  logic [DATA_W-1:0] D_in,
  output logic              CS_n,
  output logic              IORD_n,
  output logic              IOWR_n,
  input  logic              INT6_n,
  output logic              irq_pulse,
  output logic              irq_level
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENT_W = 1 + ADDR_W + DATA_W + WAIT_W;
  // Wide enough for any single phase, including the longest strobe.
  localparam int CNT_W = $clog2(T_SETUP + T_STROBE + (1 << WAIT_W) + T_HOLD + T_RECOVER + 1) + 1;
  localparam int REC_LOAD = (T_RECOVER > 0) ? (T_RECOVER - 1) : 0;
  localparam bit HAS_RECOVER = (T_RECOVER > 0);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  // ---------------------------------------------------------------------
  // Command queue
  // ---------------------------------------------------------------------
  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [ENT_W-1:0]  w_head;
  logic              w_head_rnw;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_wdata;
  logic [WAIT_W-1:0] w_head_wait;

  // Full is decided from the registered count only, so a pop in the same
  // cycle never frees a slot for a simultaneous push.
  assign w_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_empty   = (r_count == (PTR_W+1)'(0));
  assign w_push    = cmd_valid && !w_full;
  assign cmd_ready = !w_full;

  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_rnw   = w_head[ENT_W-1];
  assign w_head_addr  = w_head[ENT_W-2 -: ADDR_W];
  assign w_head_wdata = w_head[WAIT_W +: DATA_W];
  assign w_head_wait  = w_head[WAIT_W-1:0];

  // Queue storage write; contents need no reset since pointers gate them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_rnw, cmd_addr, cmd_wdata, cmd_wait};
    end
  end

  // Queue pointers and occupancy; reset flushes any pending commands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Bus sequencer
  // ---------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_cnt_zero;
  logic [CNT_W-1:0]  w_strobe_load;
  logic              r_rnw;
  logic              w_rnw_nxt;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_nxt;

  logic              r_cs_n,   w_cs_n_nxt;
  logic              r_iord_n, w_iord_n_nxt;
  logic              r_iowr_n, w_iowr_n_nxt;
  logic [ADDR_W-1:0] r_a,      w_a_nxt;
  logic [DATA_W-1:0] r_d_out,  w_d_out_nxt;
  logic              r_d_oe,   w_d_oe_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic              r_rsp_rnw,   w_rsp_rnw_nxt;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;

  assign w_cnt_zero    = (r_cnt == '0);
  // Zero-extended sum cannot wrap: the counter is wider than T_STROBE-1+max wait.
  assign w_strobe_load = CNT_W'(T_STROBE - 1) + CNT_W'(r_wait);

  // Next-state, phase counter and next values of every registered output.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_pop           = 1'b0;
    w_rnw_nxt       = r_rnw;
    w_wait_nxt      = r_wait;
    w_cs_n_nxt      = r_cs_n;
    w_iord_n_nxt    = r_iord_n;
    w_iowr_n_nxt    = r_iowr_n;
    w_a_nxt         = r_a;
    w_d_out_nxt     = r_d_out;
    w_d_oe_nxt      = r_d_oe;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rnw_nxt   = r_rsp_rnw;
    w_rsp_rdata_nxt = r_rsp_rdata;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_rnw_nxt   = w_head_rnw;
          w_wait_nxt  = w_head_wait;
          w_cs_n_nxt  = 1'b0;
          w_a_nxt     = w_head_addr;
          w_d_oe_nxt  = !w_head_rnw;
          w_d_out_nxt = w_head_wdata;
          w_state_nxt = ST_SETUP;
          w_cnt_nxt   = CNT_W'(T_SETUP - 1);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (w_cnt_zero) begin
          // Only the strobe matching the access direction is driven low.
          w_iord_n_nxt = !r_rnw;
          w_iowr_n_nxt = r_rnw;
          w_state_nxt  = ST_STROBE;
          w_cnt_nxt    = w_strobe_load;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (w_cnt_zero) begin
          w_iord_n_nxt = 1'b1;
          w_iowr_n_nxt = 1'b1;
          // Read data is captured on the same edge the strobe rises.
          if (r_rnw) begin
            w_rsp_rdata_nxt = D_in;
          end else begin
            w_rsp_rdata_nxt = r_rsp_rdata;
          end
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = CNT_W'(T_HOLD - 1);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (w_cnt_zero) begin
          w_cs_n_nxt      = 1'b1;
          w_d_oe_nxt      = 1'b0;
          w_a_nxt         = '0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rnw_nxt   = r_rnw;
          if (HAS_RECOVER) begin
            w_state_nxt = ST_RECOVER;
            w_cnt_nxt   = CNT_W'(REC_LOAD);
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_RECOVER: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Sequencer state and all bus/response output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rnw       <= 1'b0;
      r_wait      <= '0;
      r_cs_n      <= 1'b1;
      r_iord_n    <= 1'b1;
      r_iowr_n    <= 1'b1;
      r_a         <= '0;
      r_d_out     <= '0;
      r_d_oe      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rnw   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rnw       <= w_rnw_nxt;
      r_wait      <= w_wait_nxt;
      r_cs_n      <= w_cs_n_nxt;
      r_iord_n    <= w_iord_n_nxt;
      r_iowr_n    <= w_iowr_n_nxt;
      r_a         <= w_a_nxt;
      r_d_out     <= w_d_out_nxt;
      r_d_oe      <= w_d_oe_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rnw   <= w_rsp_rnw_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
    end
  end

  assign CS_n      = r_cs_n;
  assign IORD_n    = r_iord_n;
  assign IOWR_n    = r_iowr_n;
  assign A         = r_a;
  assign D_out     = r_d_out;
  assign D_oe      = r_d_oe;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rnw   = r_rsp_rnw;
  assign rsp_rdata = r_rsp_rdata;

  // ---------------------------------------------------------------------
  // Interrupt synchroniser
  // ---------------------------------------------------------------------
  logic r_int_s1;
  logic r_int_s2;
  logic r_int_prev;
  logic r_irq_pulse;
  logic r_irq_level;

  // Two-flop synchroniser on INT6_n, then registered level and fall detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_int_s1    <= 1'b1;
      r_int_s2    <= 1'b1;
      r_int_prev  <= 1'b1;
      r_irq_pulse <= 1'b0;
      r_irq_level <= 1'b0;
    end else begin
      r_int_s1    <= INT6_n;
      r_int_s2    <= r_int_s1;
      r_int_prev  <= r_int_s2;
      r_irq_pulse <= r_int_prev && !r_int_s2;
      r_irq_level <= !r_int_s2;
    end
  end

  assign irq_pulse = r_irq_pulse;
  assign irq_level = r_irq_level;

endmodule

// File: tb/tb_clockport_master.sv
// Self-checking bench for clockport_master with default parameters
// (T_SETUP=2, T_STROBE=3, T_HOLD=1, T_RECOVER=1, WAIT_W=3).
module tb_clockport_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rnw;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic [2:0] cmd_wait;
  logic       rsp_valid;
  logic       rsp_rnw;
  logic [7:0] rsp_rdata;
  logic [1:0] A;
  logic [7:0] D_out;
  logic       D_oe;
  logic [7:0] D_in;
  logic       CS_n;
  logic       IORD_n;
  logic       IOWR_n;
  logic       INT6_n;
  logic       irq_pulse;
  logic       irq_level;

  int n_checks = 0;
  int n_errors = 0;

  clockport_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wait(cmd_wait),
    .rsp_valid(rsp_valid), .rsp_rnw(rsp_rnw), .rsp_rdata(rsp_rdata),
    .A(A), .D_out(D_out), .D_oe(D_oe), .D_in(D_in),
    .CS_n(CS_n), .IORD_n(IORD_n), .IOWR_n(IOWR_n),
    .INT6_n(INT6_n), .irq_pulse(irq_pulse), .irq_level(irq_level)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  typedef struct {
    logic       rnw;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [2:0] wt;
    logic [7:0] din;
    int         exp_sf;    // edge after which the strobe is first low
    int         exp_sr;    // edge after which the strobe is high again
    int         exp_csr;   // edge after which CS_n is high and rsp_valid is 1
    logic [7:0] exp_rdata; // rsp_rdata after the access
    int         irq_edge;  // edge after which INT6_n is pulled low (-1: never)
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one command accepted at edge 0 and watch its bus cycle.
  task automatic run_vec(input int idx, input vec_t v);
    int cs_f = -1, sf = -1, sr = -1, cs_r = -1, rsp_e = -1, rsp_n = 0;
    int pulse_e = -1, pulse_n = 0;
    logic rsp_rnw_seen = 1'b0;
    logic bad_a = 1'b0, bad_d = 1'b0, wrong = 1'b0, bad_idle = 1'b0;
    logic stb, other;
    string tag;
    tag = $sformatf("v%0d", idx);
    D_in = v.din;
    chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_rnw = v.rnw; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wait = v.wt;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      stb   = v.rnw ? IORD_n : IOWR_n;
      other = v.rnw ? IOWR_n : IORD_n;
      if (!other) wrong = 1'b1;
      if (!CS_n && cs_f < 0) cs_f = e;
      if (!stb && sf < 0) sf = e;
      if (stb && sf >= 0 && sr < 0) sr = e;
      if (CS_n && cs_f >= 0 && cs_r < 0) cs_r = e;
      if (!CS_n) begin
        if (A !== v.addr) bad_a = 1'b1;
        if (D_oe !== !v.rnw) bad_d = 1'b1;
        if (!v.rnw && D_out !== v.wdata) bad_d = 1'b1;
      end else if (cs_f >= 0) begin
        if (D_oe !== 1'b0 || A !== 2'd0) bad_idle = 1'b1;
      end
      if (rsp_valid) begin
        rsp_n++;
        if (rsp_e < 0) begin
          rsp_e = e;
          rsp_rnw_seen = rsp_rnw;
        end
      end
      if (irq_pulse) begin
        pulse_n++;
        if (pulse_e < 0) pulse_e = e;
      end
      if (e == v.irq_edge) begin
        #2 INT6_n = 1'b0;
      end
    end
    chk({tag, "_cs_fall"},   cs_f, 32'd1);
    chk({tag, "_stb_fall"},  sf, v.exp_sf);
    chk({tag, "_stb_rise"},  sr, v.exp_sr);
    chk({tag, "_cs_rise"},   cs_r, v.exp_csr);
    chk({tag, "_rsp_edge"},  rsp_e, v.exp_csr);
    chk({tag, "_rsp_count"}, rsp_n, 32'd1);
    chk({tag, "_rsp_rnw"},   {31'd0, rsp_rnw_seen}, {31'd0, v.rnw});
    chk({tag, "_rdata"},     {24'd0, rsp_rdata}, {24'd0, v.exp_rdata});
    chk({tag, "_addr"},      {31'd0, bad_a}, 32'd0);
    chk({tag, "_data_oe"},   {31'd0, bad_d}, 32'd0);
    chk({tag, "_idle_bus"},  {31'd0, bad_idle}, 32'd0);
    chk({tag, "_wrong_stb"}, {31'd0, wrong}, 32'd0);
    chk({tag, "_irq_count"}, pulse_n, (v.irq_edge >= 0) ? 32'd1 : 32'd0);
    if (v.irq_edge >= 0) begin
      chk({tag, "_irq_latency_ok"},
          {31'd0, (pulse_e - v.irq_edge >= 2) && (pulse_e - v.irq_edge <= 3)}, 32'd1);
      chk({tag, "_irq_level"}, {31'd0, irq_level}, 32'd1);
    end
  endtask

  initial begin
    // Table: hand-computed edges with CS_n falling after edge 1.
    //                rnw   addr   wdata   wt    din     sf sr  csr rdata  irq
    vecs[0] = '{1'b0, 2'd2, 8'hA5, 3'd0, 8'h00, 3, 6,  7,  8'h00, -1};
    vecs[1] = '{1'b1, 2'd1, 8'h00, 3'd2, 8'h3C, 3, 8,  9,  8'h3C, -1};
    vecs[2] = '{1'b0, 2'd3, 8'h5A, 3'd1, 8'hFF, 3, 7,  8,  8'h3C, -1};
    vecs[3] = '{1'b1, 2'd0, 8'h00, 3'd7, 8'hC3, 3, 13, 14, 8'hC3, -1};
    vecs[4] = '{1'b1, 2'd1, 8'h00, 3'd0, 8'h77, 3, 6,  7,  8'h77, 4};

    reset = 1'b1; INT6_n = 1'b1; cmd_valid = 1'b0; cmd_rnw = 1'b0;
    cmd_addr = 2'd0; cmd_wdata = 8'h00; cmd_wait = 3'd0; D_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n",   {31'd0, CS_n}, 32'd1);
    chk("rst_iord_n", {31'd0, IORD_n}, 32'd1);
    chk("rst_iowr_n", {31'd0, IOWR_n}, 32'd1);
    chk("rst_d_oe",   {31'd0, D_oe}, 32'd0);
    chk("rst_ready",  {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp",    {31'd0, rsp_valid}, 32'd0);
    chk("rst_irq",    {30'd0, irq_pulse, irq_level}, 32'd0);
    chk("rst_a_d",    {22'd0, A, D_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      run_vec(i, vecs[i]);
    end

    // Interrupt release: level drops, no new pulse.
    begin
      int pn = 0;
      INT6_n = 1'b1;
      for (int e = 0; e < 6; e++) begin
        @(posedge clk); #1;
        if (irq_pulse) pn++;
      end
      chk("irq_release_level", {31'd0, irq_level}, 32'd0);
      chk("irq_release_pulse", pn, 32'd0);
    end

    // Queue full / back-to-back: six writes offered continuously.
    begin
      int n_acc = 0, first_full = -1, n_cs = 0, gap = 0, n_rsp = 0;
      logic prev_cs = 1'b1;
      logic ready_b;
      logic [7:0] seen_d [6];
      for (int i = 0; i < 6; i++) seen_d[i] = 8'h00;
      cmd_rnw = 1'b0; cmd_wait = 3'd0; cmd_addr = 2'd0; cmd_wdata = 8'h10;
      cmd_valid = 1'b1;
      for (int e = 0; e < 100; e++) begin
        ready_b = cmd_ready;
        @(posedge clk); #1;
        if (cmd_valid && ready_b) n_acc++;
        if (!cmd_ready && first_full < 0) first_full = n_acc;
        if (n_acc < 6) begin
          cmd_valid = 1'b1;
          cmd_addr  = 2'(n_acc);
          cmd_wdata = 8'h10 + 8'(n_acc);
        end else begin
          cmd_valid = 1'b0;
        end
        if (rsp_valid) n_rsp++;
        if (!CS_n && prev_cs) begin
          if (n_cs > 0) chk($sformatf("q_gap%0d", n_cs), gap, 32'd2);
          if (n_cs < 6) seen_d[n_cs] = D_out;
          n_cs++;
          gap = 0;
        end else if (CS_n && n_cs > 0) begin
          gap++;
        end
        prev_cs = CS_n;
      end
      chk("q_full_at", first_full, 32'd5);
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("q_order%0d", i), {24'd0, seen_d[i]}, 32'h10 + 32'(i));
      end
      chk("q_accesses", n_cs, 32'd6);
      chk("q_rsp", n_rsp, 32'd6);
    end

    // Reset in the middle of a write strobe with more commands queued.
    begin
      int guard = 0;
      logic bad = 1'b0;
      cmd_rnw = 1'b0; cmd_wait = 3'd3; cmd_addr = 2'd1; cmd_wdata = 8'h99;
      cmd_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      while (IOWR_n && guard < 20) begin
        @(posedge clk); #1;
        guard++;
      end
      chk("mid_reach_strobe", {31'd0, IOWR_n}, 32'd0);
      #3 reset = 1'b1;
      #1;
      chk("mid_iowr_n", {31'd0, IOWR_n}, 32'd1);
      chk("mid_cs_n",   {31'd0, CS_n}, 32'd1);
      chk("mid_d_oe",   {31'd0, D_oe}, 32'd0);
      chk("mid_ready",  {31'd0, cmd_ready}, 32'd1);
      chk("mid_rdata",  {24'd0, rsp_rdata}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int e = 0; e < 30; e++) begin
        @(posedge clk); #1;
        if (!CS_n || rsp_valid || !IOWR_n) bad = 1'b1;
      end
      chk("mid_flushed", {31'd0, bad}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
